// File: rtl/mmcm_reset_sequencer.sv
// MMCM reset sequencer.
// Pulses the MMCM reset and waits for a synchronised lock, with a timeout and a
// bounded number of retries. Lock must then hold for a number of cycles before
// the downstream reset is released. Losing lock while running restarts the
// sequence. Every output comes straight from a register. Clock-to-q delays are
// not modelled, so the RTL contains no timing controls.
module mmcm_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 10000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned RETRY_MAX           = 4
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       mmcm_locked,
  input  logic       force_reset,
  output logic       mmcm_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [7:0] lost_count
);

  // One counter is shared by the pulse, timeout and stable phases because
  // only one of them is ever active. It is sized for the longest phase.
  localparam int unsigned MaxAB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCnt = (MaxAB > LOCK_STABLE_CYCLES) ? MaxAB : LOCK_STABLE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] PulseLast   = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]      RetryLimit  = 8'(RETRY_MAX);

  typedef enum logic [2:0] {
    RESET_PULSE = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RUN         = 3'd3,
    FAIL        = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      retry_q, retry_d;
  logic [7:0]      lost_q, lost_d;
  logic            lockLost_q, lockLost_d;
  logic            mmcmReset_q;
  logic            run_q;
  logic            fail_q;
  logic            lockedMeta_q;
  logic            lockedSync_q;

  // Bring the asynchronous LOCKED signal into the clk_in domain with two flops.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      lockedMeta_q <= 1'b0;
      lockedSync_q <= 1'b0;
    end else begin
      lockedMeta_q <= mmcm_locked;
      lockedSync_q <= lockedMeta_q;
    end
  end

  // Next-state logic. A software restart overrides the sequence from any state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    lost_d     = lost_q;
    lockLost_d = 1'b0;
    if (force_reset) begin
      state_d = RESET_PULSE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PULSE: begin
          if (cnt_q == PulseLast) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lockedSync_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_d = '0;
            if (retry_q != 8'hFF) begin
              retry_d = retry_q + 8'd1;
            end
            if ((RETRY_MAX != 0) && (retry_d == RetryLimit)) begin
              state_d = FAIL;
            end else begin
              state_d = RESET_PULSE;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        STABLE: begin
          if (!lockedSync_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        RUN: begin
          if (!lockedSync_q) begin
            state_d    = RESET_PULSE;
            cnt_d      = '0;
            retry_d    = '0;
            lockLost_d = 1'b1;
            if (lost_q != 8'hFF) begin
              lost_d = lost_q + 8'd1;
            end
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = RESET_PULSE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs, all decoded from the next state.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q     <= RESET_PULSE;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      lockLost_q  <= 1'b0;
      mmcmReset_q <= 1'b1;
      run_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      lockLost_q  <= lockLost_d;
      mmcmReset_q <= (state_d == RESET_PULSE) || (state_d == FAIL);
      run_q       <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign mmcm_reset  = mmcmReset_q;
  assign sys_rst_n   = run_q;
  assign ready       = run_q;
  assign fail        = fail_q;
  assign lock_lost   = lockLost_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Directed bench for mmcm_reset_sequencer with a short pulse, timeout and
// stable window. The MMCM lock input is driven by hand: it rises 10 cycles
// after mmcm_reset falls, or stays low to provoke retries.
module tb_mmcm_reset_sequencer;

  logic       clk_in;
  logic       reset_n;
  logic       mmcm_locked;
  logic       force_reset;
  logic       mmcm_reset;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [7:0] lost_count;

  logic       reset_n0;
  logic       mmcm_locked0;
  logic       force_reset0;
  logic       mmcm_reset0;
  logic       sys_rst_n0;
  logic       ready0;
  logic       fail0;
  logic       lock_lost0;
  logic [7:0] retry_count0;
  logic [7:0] lost_count0;

  int compared;
  int mismatched;

  mmcm_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .RETRY_MAX          (2)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .mmcm_locked(mmcm_locked),
    .force_reset(force_reset),
    .mmcm_reset (mmcm_reset),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .lost_count (lost_count)
  );

  // A second instance that retries forever, used for the saturation check.
  mmcm_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .RETRY_MAX          (0)
  ) dutForever (
    .clk_in     (clk_in),
    .reset_n    (reset_n0),
    .mmcm_locked(mmcm_locked0),
    .force_reset(force_reset0),
    .mmcm_reset (mmcm_reset0),
    .sys_rst_n  (sys_rst_n0),
    .ready      (ready0),
    .fail       (fail0),
    .lock_lost  (lock_lost0),
    .retry_count(retry_count0),
    .lost_count (lost_count0)
  );

  // Free-running board clock, 10 ns period.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance a number of rising edges, leaving time 1 ns past the last one so
  // outputs are settled and new inputs land well before the next edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Whole directed sequence; edge offsets in comments are relative to the
  // edge where mmcm_reset falls (F) or where RESET_PULSE is entered.
  initial begin
    compared     = 0;
    mismatched   = 0;
    reset_n      = 1'b0;
    mmcm_locked  = 1'b0;
    force_reset  = 1'b0;
    reset_n0     = 1'b0;
    mmcm_locked0 = 1'b0;
    force_reset0 = 1'b0;

    applyStimulus(3);
    checkOutput("rst_mmcm_reset", 32'(mmcm_reset), 32'd1);
    checkOutput("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_fail", 32'(fail), 32'd0);
    checkOutput("rst_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("rst_retry", 32'(retry_count), 32'd0);
    checkOutput("rst_lost", 32'(lost_count), 32'd0);

    // Normal bring-up: pulse of 4, lock after 10, ready 21 edges after F.
    reset_n = 1'b1;
    applyStimulus(3);
    checkOutput("t1_pulse_edge3", 32'(mmcm_reset), 32'd1);
    applyStimulus(1);
    checkOutput("t1_pulse_fall", 32'(mmcm_reset), 32'd0);
    checkOutput("t1_sys_rst_held", 32'(sys_rst_n), 32'd0);
    applyStimulus(10);
    mmcm_locked = 1'b1;
    applyStimulus(10);
    checkOutput("t1_ready_early", 32'(ready), 32'd0);
    applyStimulus(1);
    checkOutput("t1_ready", 32'(ready), 32'd1);
    checkOutput("t1_sys_rst_n", 32'(sys_rst_n), 32'd1);
    checkOutput("t1_fail", 32'(fail), 32'd0);
    checkOutput("t1_retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN: seen by the FSM on the third edge after the drop.
    applyStimulus(5);
    mmcm_locked = 1'b0;
    applyStimulus(2);
    checkOutput("t4_ready_before", 32'(ready), 32'd1);
    checkOutput("t4_lost_pulse_before", 32'(lock_lost), 32'd0);
    applyStimulus(1);
    checkOutput("t4_lock_lost", 32'(lock_lost), 32'd1);
    checkOutput("t4_sys_rst_n", 32'(sys_rst_n), 32'd0);
    checkOutput("t4_ready", 32'(ready), 32'd0);
    checkOutput("t4_mmcm_reset", 32'(mmcm_reset), 32'd1);
    checkOutput("t4_lost_count", 32'(lost_count), 32'd1);
    applyStimulus(1);
    checkOutput("t4_lost_pulse_end", 32'(lock_lost), 32'd0);
    applyStimulus(2);
    checkOutput("t4_pulse_edge3", 32'(mmcm_reset), 32'd1);
    applyStimulus(1);
    checkOutput("t4_pulse_fall", 32'(mmcm_reset), 32'd0);
    applyStimulus(10);
    mmcm_locked = 1'b1;
    applyStimulus(10);
    checkOutput("t4_ready_early", 32'(ready), 32'd0);
    applyStimulus(1);
    checkOutput("t4_re_release", 32'(ready), 32'd1);
    checkOutput("t4_lost_kept", 32'(lost_count), 32'd1);

    // Restart, then glitch lock low for one cycle during the 5th STABLE cycle.
    force_reset = 1'b1;
    mmcm_locked = 1'b0;
    applyStimulus(1);
    force_reset = 1'b0;
    checkOutput("t3_force_mmcm_reset", 32'(mmcm_reset), 32'd1);
    checkOutput("t3_force_ready", 32'(ready), 32'd0);
    checkOutput("t3_force_lost_kept", 32'(lost_count), 32'd1);
    applyStimulus(4);
    checkOutput("t3_pulse_fall", 32'(mmcm_reset), 32'd0);
    applyStimulus(10);
    mmcm_locked = 1'b1;
    applyStimulus(5);
    mmcm_locked = 1'b0;
    applyStimulus(1);
    mmcm_locked = 1'b1;
    applyStimulus(5);
    checkOutput("t3_no_release", 32'(ready), 32'd0);
    checkOutput("t3_no_retry", 32'(retry_count), 32'd0);
    applyStimulus(5);
    checkOutput("t3_ready_early", 32'(ready), 32'd0);
    applyStimulus(1);
    checkOutput("t3_ready", 32'(ready), 32'd1);

    // Never lock: two attempts then FAIL with the MMCM held in reset.
    force_reset = 1'b1;
    mmcm_locked = 1'b0;
    applyStimulus(1);
    force_reset = 1'b0;
    applyStimulus(4);
    checkOutput("t2_pulse1_fall", 32'(mmcm_reset), 32'd0);
    applyStimulus(19);
    checkOutput("t2_wait1_end", 32'(mmcm_reset), 32'd0);
    checkOutput("t2_retry0", 32'(retry_count), 32'd0);
    applyStimulus(1);
    checkOutput("t2_pulse2_rise", 32'(mmcm_reset), 32'd1);
    checkOutput("t2_retry1", 32'(retry_count), 32'd1);
    checkOutput("t2_fail_early", 32'(fail), 32'd0);
    applyStimulus(3);
    checkOutput("t2_pulse2_edge3", 32'(mmcm_reset), 32'd1);
    applyStimulus(1);
    checkOutput("t2_pulse2_fall", 32'(mmcm_reset), 32'd0);
    applyStimulus(19);
    checkOutput("t2_wait2_retry", 32'(retry_count), 32'd1);
    checkOutput("t2_wait2_fail", 32'(fail), 32'd0);
    applyStimulus(1);
    checkOutput("t2_fail", 32'(fail), 32'd1);
    checkOutput("t2_retry2", 32'(retry_count), 32'd2);
    checkOutput("t2_mmcm_held", 32'(mmcm_reset), 32'd1);
    checkOutput("t2_sys_rst_n", 32'(sys_rst_n), 32'd0);
    checkOutput("t2_ready", 32'(ready), 32'd0);
    applyStimulus(30);
    checkOutput("t2_fail_hold", 32'(fail), 32'd1);
    checkOutput("t2_mmcm_hold", 32'(mmcm_reset), 32'd1);

    // Leave FAIL through force_reset and complete a normal bring-up.
    force_reset = 1'b1;
    applyStimulus(1);
    force_reset = 1'b0;
    checkOutput("t5_fail_clear", 32'(fail), 32'd0);
    checkOutput("t5_retry_clear", 32'(retry_count), 32'd0);
    checkOutput("t5_mmcm_reset", 32'(mmcm_reset), 32'd1);
    applyStimulus(4);
    checkOutput("t5_pulse_fall", 32'(mmcm_reset), 32'd0);
    applyStimulus(10);
    mmcm_locked = 1'b1;
    applyStimulus(10);
    checkOutput("t5_ready_early", 32'(ready), 32'd0);
    applyStimulus(1);
    checkOutput("t5_ready", 32'(ready), 32'd1);
    checkOutput("t5_lost_kept", 32'(lost_count), 32'd1);

    // reset_n asserted while in STABLE returns every output to reset values.
    force_reset = 1'b1;
    mmcm_locked = 1'b0;
    applyStimulus(1);
    force_reset = 1'b0;
    applyStimulus(4);
    applyStimulus(10);
    mmcm_locked = 1'b1;
    applyStimulus(5);
    checkOutput("t6_in_stable", 32'(mmcm_reset), 32'd0);
    reset_n = 1'b0;
    applyStimulus(1);
    checkOutput("t6_mmcm_reset", 32'(mmcm_reset), 32'd1);
    checkOutput("t6_sys_rst_n", 32'(sys_rst_n), 32'd0);
    checkOutput("t6_ready", 32'(ready), 32'd0);
    checkOutput("t6_fail", 32'(fail), 32'd0);
    checkOutput("t6_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("t6_retry", 32'(retry_count), 32'd0);
    checkOutput("t6_lost", 32'(lost_count), 32'd0);

    // Retry-forever instance: one attempt every 24 edges, count saturates.
    reset_n0 = 1'b1;
    applyStimulus(24 * 254 - 1);
    checkOutput("t6_forever_253", 32'(retry_count0), 32'd253);
    applyStimulus(1);
    checkOutput("t6_forever_254", 32'(retry_count0), 32'd254);
    applyStimulus(24);
    checkOutput("t6_forever_255", 32'(retry_count0), 32'd255);
    applyStimulus(24 * 45);
    checkOutput("t6_forever_sat", 32'(retry_count0), 32'd255);
    checkOutput("t6_forever_fail", 32'(fail0), 32'd0);
    checkOutput("t6_forever_pulse", 32'(mmcm_reset0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
